// File: rtl/irq_conditioner.sv
// Purpose    : synchronise, debounce and edge-detect raw board interrupt lines into 1-cycle irq pulses.
// Latency    : a raw_i change set up before edge 1 gives an irq_src_o pulse after edge N+3 (N = max(DEBOUNCE_CNT,1)).
// Backpressure: none; events on a disabled channel (en_i=0) are dropped, never queued.
//
// Ports:
//   wb_clk_i    - system clock (wishbone domain)
//   wb_rst_n_i  - synchronous active-low reset
//   raw_i       - raw asynchronous interrupt lines, one per channel
//   en_i        - per-channel enable, sampled with the output register
//   irq_src_o   - registered one-cycle event pulses
//   lvl_o       - debounced synchronised levels; present only when IRQ_CONDITIONER_LEVEL_EN is defined
//
// Optional feature macro: IRQ_CONDITIONER_LEVEL_EN (adds lvl_o; pulse behaviour is unchanged).
// DEBOUNCE_CNT must be < 2**DEBOUNCE_W; a value of 0 behaves as 1.

module irq_conditioner #(
    parameter int unsigned     NSRC         = 4,
    parameter int unsigned     DEBOUNCE_W   = 8,
    parameter int unsigned     DEBOUNCE_CNT = 100,
    parameter logic [NSRC-1:0] EDGE_POL     = '0,
    parameter logic [NSRC-1:0] BOTH_EDGES   = '0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic [NSRC-1:0] raw_i,
    input  logic [NSRC-1:0] en_i,
`ifdef IRQ_CONDITIONER_LEVEL_EN
    output logic [NSRC-1:0] lvl_o,
`endif
    output logic [NSRC-1:0] irq_src_o
);

    // A zero debounce count still needs one cycle of agreement, so clamp to 1.
    localparam int unsigned           N_EFF   = (DEBOUNCE_CNT == 0) ? 1 : DEBOUNCE_CNT;
    localparam logic [DEBOUNCE_W-1:0] CNT_MAX = DEBOUNCE_W'(N_EFF - 1);
    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1);

    // Synchroniser stages
    logic [NSRC-1:0]       s1_q;
    logic [NSRC-1:0]       s2_q;

    // Debounce state
    logic [NSRC-1:0]       lvl_q;
    logic [NSRC-1:0]       lvl_d;
    logic [DEBOUNCE_W-1:0] cnt_q [NSRC];
    logic [DEBOUNCE_W-1:0] cnt_d [NSRC];

    // Edge detect / output
    logic [NSRC-1:0]       lvl_dly_q;
    logic [NSRC-1:0]       rise;
    logic [NSRC-1:0]       fall;
    logic [NSRC-1:0]       ev;
    logic [NSRC-1:0]       irq_q;
    logic [NSRC-1:0]       irq_d;

    // ------------------------------------------------------------------
    // 2-FF synchroniser: raw_i feeds nothing but s1.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the synchronised line must disagree with the accepted
    // level for N consecutive cycles before the level flips. Any cycle
    // of agreement discards the partial count. The counter stops at
    // N-1 because the flip itself clears it, so it can never wrap.
    // ------------------------------------------------------------------
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < NSRC; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    lvl_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            lvl_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            lvl_q <= lvl_d;
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detect on the debounced level. BOTH_EDGES takes priority
    // over EDGE_POL per channel.
    // ------------------------------------------------------------------
    assign rise = lvl_q & ~lvl_dly_q;
    assign fall = ~lvl_q & lvl_dly_q;
    assign ev   = (BOTH_EDGES & (rise | fall))
                | (~BOTH_EDGES & ((EDGE_POL & fall) | (~EDGE_POL & rise)));

    // Enable gates the event in the same cycle it is registered; a
    // masked event is lost for good because ev only lasts one cycle.
    assign irq_d = ev & en_i;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            lvl_dly_q <= '0;
            irq_q     <= '0;
        end else begin
            lvl_dly_q <= lvl_q;
            irq_q     <= irq_d;
        end
    end

    assign irq_src_o = irq_q;

`ifdef IRQ_CONDITIONER_LEVEL_EN
    assign lvl_o = lvl_q;
`endif

endmodule

// File: tb/tb_irq_conditioner.sv
// Purpose    : directed self-checking bench for irq_conditioner (DEBOUNCE_CNT=4, so pulses land 7 edges after a change).
// Latency    : n/a (bench).
// Backpressure: n/a (bench).

module tb_irq_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw;
    logic [3:0] en;
    logic [3:0] irq;
`ifdef IRQ_CONDITIONER_LEVEL_EN
    logic [3:0] lvl;
    logic [3:0] lvl_snap [0:127];
`endif

    int         checks = 0;
    int         errors = 0;

    // Per-window capture, indexed by edge number k (k=1 is the first edge
    // after the inputs of the first tick were applied).
    int         k;
    logic [3:0] snap [0:127];
    int         hi_cnt  [4];
    int         first_e [4];
    int         last_e  [4];

    irq_conditioner #(
        .NSRC         (4),
        .DEBOUNCE_W   (8),
        .DEBOUNCE_CNT (4),
        .EDGE_POL     (4'b0010),
        .BOTH_EDGES   (4'b0100)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .raw_i      (raw),
        .en_i       (en),
`ifdef IRQ_CONDITIONER_LEVEL_EN
        .lvl_o      (lvl),
`endif
        .irq_src_o  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_stats();
        k = 0;
        for (int b = 0; b < 4; b++) begin
            hi_cnt[b]  = 0;
            first_e[b] = 0;
            last_e[b]  = 0;
        end
        for (int i = 0; i < 128; i++) snap[i] = 4'h0;
    endtask

    // Apply inputs (called just after a falling edge), step one rising
    // edge, then sample the outputs at the following falling edge.
    task automatic tick(input logic [3:0] r, input logic [3:0] e, input logic rn);
        raw   = r;
        en    = e;
        rst_n = rn;
        @(posedge clk);
        @(negedge clk);
        k++;
        if (k < 128) begin
            snap[k] = irq;
`ifdef IRQ_CONDITIONER_LEVEL_EN
            lvl_snap[k] = lvl;
`endif
        end
        for (int b = 0; b < 4; b++) begin
            if (irq[b]) begin
                hi_cnt[b]++;
                if (first_e[b] == 0) first_e[b] = k;
                last_e[b] = k;
            end
        end
    endtask

    task automatic test_reset();
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            tick(4'h0, 4'hF, 1'b0);
            checks++;
            if (irq !== 4'h0) begin
                errors++;
                $display("FAIL reset_irq: got %b want 0000", irq);
            end
        end
`ifdef IRQ_CONDITIONER_LEVEL_EN
        checks++;
        if (lvl !== 4'h0) begin
            errors++;
            $display("FAIL reset_lvl: got %b want 0000", lvl);
        end
`endif
    endtask

    // Lines held high through reset produce one rising event per channel
    // configured for it; then dropping them exercises falling/both edges.
    task automatic test_powerup();
        tick(4'hF, 4'hF, 1'b0);
        tick(4'hF, 4'hF, 1'b0);
        checks++;
        if (irq !== 4'h0) begin
            errors++;
            $display("FAIL powerup_in_reset: got %b want 0000", irq);
        end
        clear_stats();
        for (int i = 0; i < 14; i++) tick(4'hF, 4'hF, 1'b1);
        checks++;
        if (snap[7] !== 4'b1101) begin
            errors++;
            $display("FAIL powerup_rise_edge7: got %b want 1101", snap[7]);
        end
        checks++;
        if (hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3] != 3) begin
            errors++;
            $display("FAIL powerup_rise_total: got %0d want 3", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]);
        end
        clear_stats();
        for (int i = 0; i < 14; i++) tick(4'h0, 4'hF, 1'b1);
        checks++;
        if (snap[7] !== 4'b0110) begin
            errors++;
            $display("FAIL powerup_fall_edge7: got %b want 0110", snap[7]);
        end
        checks++;
        if (hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3] != 2) begin
            errors++;
            $display("FAIL powerup_fall_total: got %0d want 2", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]);
        end
    endtask

    task automatic test_ch0_rise();
        clear_stats();
        for (int i = 0; i < 20; i++) tick(4'b0001, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[0] != 1 || first_e[0] != 7) begin
            errors++;
            $display("FAIL ch0_rise: got count %0d at edge %0d want count 1 at edge 7", hi_cnt[0], first_e[0]);
        end
        checks++;
        if (snap[7] !== 4'b0001) begin
            errors++;
            $display("FAIL ch0_rise_only_bit: got %b want 0001", snap[7]);
        end
        checks++;
        if (snap[6] !== 4'b0000 || snap[8] !== 4'b0000) begin
            errors++;
            $display("FAIL ch0_rise_width: got %b/%b around pulse want 0000/0000", snap[6], snap[8]);
        end
        clear_stats();
        for (int i = 0; i < 20; i++) tick(4'b0000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3] != 0) begin
            errors++;
            $display("FAIL ch0_fall_no_pulse: got %0d pulses want 0", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]);
        end
    endtask

    task automatic test_glitch();
        clear_stats();
        for (int i = 0; i < 3; i++)  tick(4'b0001, 4'hF, 1'b1);
        for (int i = 0; i < 15; i++) tick(4'b0000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[0] != 0) begin
            errors++;
            $display("FAIL glitch3: got %0d pulses want 0", hi_cnt[0]);
        end
        // Back-to-back: a second short glitch must also be discarded, proving the count restarted.
        clear_stats();
        for (int i = 0; i < 3; i++)  tick(4'b0001, 4'hF, 1'b1);
        tick(4'b0000, 4'hF, 1'b1);
        for (int i = 0; i < 2; i++)  tick(4'b0001, 4'hF, 1'b1);
        for (int i = 0; i < 15; i++) tick(4'b0000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[0] != 0) begin
            errors++;
            $display("FAIL glitch_back_to_back: got %0d pulses want 0", hi_cnt[0]);
        end
        clear_stats();
        for (int i = 0; i < 4; i++)  tick(4'b0001, 4'hF, 1'b1);
        for (int i = 0; i < 16; i++) tick(4'b0000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[0] != 1 || first_e[0] != 7) begin
            errors++;
            $display("FAIL glitch4: got count %0d at edge %0d want count 1 at edge 7", hi_cnt[0], first_e[0]);
        end
    endtask

    task automatic test_falling_edge();
        clear_stats();
        for (int i = 0; i < 10; i++) tick(4'b0010, 4'hF, 1'b1);
        for (int i = 0; i < 20; i++) tick(4'b0000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[1] != 1 || first_e[1] != 17) begin
            errors++;
            $display("FAIL ch1_fall: got count %0d at edge %0d want count 1 at edge 17", hi_cnt[1], first_e[1]);
        end
        checks++;
        if (snap[7] !== 4'b0000) begin
            errors++;
            $display("FAIL ch1_no_rise_pulse: got %b want 0000", snap[7]);
        end
    endtask

    task automatic test_both_edges();
        clear_stats();
        for (int i = 0; i < 10; i++) tick(4'b0100, 4'hF, 1'b1);
        for (int i = 0; i < 20; i++) tick(4'b0000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[2] != 2 || first_e[2] != 7 || last_e[2] != 17) begin
            errors++;
            $display("FAIL ch2_both: got count %0d edges %0d,%0d want count 2 edges 7,17", hi_cnt[2], first_e[2], last_e[2]);
        end
    endtask

    task automatic test_enable();
        clear_stats();
        for (int i = 0; i < 12; i++) tick(4'b1000, 4'b0111, 1'b1);
        for (int i = 0; i < 10; i++) tick(4'b1000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[3] != 0) begin
            errors++;
            $display("FAIL en_drop: got %0d pulses want 0", hi_cnt[3]);
        end
        clear_stats();
        for (int i = 0; i < 15; i++) tick(4'b0000, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[3] != 0) begin
            errors++;
            $display("FAIL ch3_fall_no_pulse: got %0d pulses want 0", hi_cnt[3]);
        end
        clear_stats();
        for (int i = 0; i < 15; i++) tick(4'b1001, 4'hF, 1'b1);
        checks++;
        if (snap[7] !== 4'b1001) begin
            errors++;
            $display("FAIL simultaneous: got %b want 1001", snap[7]);
        end
        checks++;
        if (hi_cnt[0] != 1 || hi_cnt[3] != 1) begin
            errors++;
            $display("FAIL simultaneous_count: got %0d/%0d want 1/1", hi_cnt[0], hi_cnt[3]);
        end
        for (int i = 0; i < 15; i++) tick(4'b0000, 4'hF, 1'b1);
    endtask

    task automatic test_reset_mid();
        clear_stats();
        for (int i = 0; i < 4; i++)  tick(4'b0001, 4'hF, 1'b1);
        tick(4'b0001, 4'hF, 1'b0);
        for (int i = 0; i < 14; i++) tick(4'b0001, 4'hF, 1'b1);
        checks++;
        if (hi_cnt[0] != 1 || first_e[0] != 12) begin
            errors++;
            $display("FAIL reset_mid: got count %0d at edge %0d want count 1 at edge 12", hi_cnt[0], first_e[0]);
        end
`ifdef IRQ_CONDITIONER_LEVEL_EN
        checks++;
        if (lvl_snap[10][0] !== 1'b0 || lvl_snap[11][0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_lvl: got %b,%b want 0,1", lvl_snap[10][0], lvl_snap[11][0]);
        end
`endif
        for (int i = 0; i < 15; i++) tick(4'b0000, 4'hF, 1'b1);
    endtask

    initial begin
        raw   = 4'h0;
        en    = 4'hF;
        rst_n = 1'b0;
        test_reset();
        test_powerup();
        test_ch0_rise();
        test_glitch();
        test_falling_edge();
        test_both_edges();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
